// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: LC-3 memory / memory-mapped I/O access controller.
// Holds MAR/MDR and sequences fixed-latency external memory reads and writes.
// Decodes device registers at DEV_BASE and above:
//   KBSR xFE00, KBDR xFE02, DSR xFE04, DDR xFE06, MCR xFFFE.
// Generates r (ready) for the control FSM.
// Optional feature macro: LC3_MEM_INT_EN (registered keyboard interrupt request on kb_irq).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   bus_in, ld_mar, ld_mdr          system bus and register load enables
//   mio_en, r_w                     access start/hold, 1 = write
//   mar_out, mdr_out, r             register contents and access-complete flag
//   mem_addr, mem_wdata, mem_re,
//   mem_we, mem_rdata               external synchronous memory
//   kb_valid, kb_data               keyboard character input
//   disp_valid, disp_data,
//   disp_ready                      display character output
//   run, kb_irq                     MCR run bit, keyboard interrupt request
module lc3_mem_ctrl #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter logic [15:0] DEV_BASE    = 16'hFE00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bus_in,
    input  logic        ld_mar,
    input  logic        ld_mdr,
    input  logic        mio_en,
    input  logic        r_w,
    output logic [15:0] mar_out,
    output logic [15:0] mdr_out,
    output logic        r,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        run,
    output logic        kb_irq
);
    localparam int unsigned CNT_W     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;
    localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             r_q, r_d;
    logic             mem_re_q, mem_re_d;
    logic             mem_we_q, mem_we_d;

    logic [15:0] mar_q, mdr_q, mcr_q;
    logic        we_q;
    logic        kb_rdy_q, kb_ie_q;
    logic [7:0]  kbdr_q;
    logic        dsr_rdy_q, dsr_ie_q;
    logic        disp_valid_q;
    logic [7:0]  disp_data_q;

    logic        is_dev, start_mem, start_dev, mem_done;
    logic        dev_rd, dev_wr, ddr_take;
    logic [15:0] dev_rdata;

    assign is_dev    = (mar_q >= DEV_BASE);
    assign start_mem = (state_q == ST_IDLE) && mio_en && !is_dev;
    assign start_dev = (state_q == ST_IDLE) && mio_en && is_dev;
    assign mem_done  = (state_q == ST_MEM) && (cnt_q == '0);
    assign dev_rd    = start_dev && !r_w;
    assign dev_wr    = start_dev && r_w;
    // A DDR write is only accepted while the display is ready; otherwise it is dropped.
    assign ddr_take  = dev_wr && (mar_q == ADDR_DDR) && dsr_rdy_q;

    // State register and registered FSM outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            r_q      <= 1'b0;
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            mem_re_q <= mem_re_d;
            mem_we_q <= mem_we_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_mem) begin
                    state_d = ST_MEM;
                    cnt_d   = CNT_W'(MEM_LATENCY - 1);
                end else if (start_dev) begin
                    state_d = ST_DONE;
                end
            end
            ST_MEM: begin
                if (cnt_q == '0) state_d = ST_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_DONE: begin
                if (!mio_en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: strobes only in the first MEM cycle, ready only in DONE.
    always_comb begin
        r_d      = (state_d == ST_DONE);
        mem_re_d = start_mem && !r_w;
        mem_we_d = start_mem && r_w;
    end

    // Device register read mux.
    always_comb begin
        dev_rdata = 16'h0000;
        case (mar_q)
            ADDR_KBSR: dev_rdata = {kb_rdy_q, kb_ie_q, 14'h0000};
            ADDR_KBDR: dev_rdata = {8'h00, kbdr_q};
            ADDR_DSR:  dev_rdata = {dsr_rdy_q, dsr_ie_q, 14'h0000};
            ADDR_MCR:  dev_rdata = mcr_q;
            default:   dev_rdata = 16'h0000;
        endcase
    end

    // MAR/MDR and device registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar_q        <= 16'h0000;
            mdr_q        <= 16'h0000;
            we_q         <= 1'b0;
            kb_rdy_q     <= 1'b0;
            kb_ie_q      <= 1'b0;
            kbdr_q       <= 8'h00;
            dsr_rdy_q    <= 1'b1;
            dsr_ie_q     <= 1'b0;
            mcr_q        <= 16'h8000;
            disp_valid_q <= 1'b0;
            disp_data_q  <= 8'h00;
        end else begin
            if (ld_mar) mar_q <= bus_in;
            if (start_mem) we_q <= r_w;

            if (mem_done && !we_q && ld_mdr) mdr_q <= mem_rdata;
            else if (dev_rd && ld_mdr)       mdr_q <= dev_rdata;
            else if (ld_mdr && !mio_en)      mdr_q <= bus_in;

            // A new character wins over a simultaneous KBDR read.
            if (kb_valid) begin
                kb_rdy_q <= 1'b1;
                kbdr_q   <= kb_data;
            end else if (dev_rd && (mar_q == ADDR_KBDR)) begin
                kb_rdy_q <= 1'b0;
            end

            if (dev_wr && (mar_q == ADDR_KBSR)) kb_ie_q  <= mdr_q[14];
            if (dev_wr && (mar_q == ADDR_DSR))  dsr_ie_q <= mdr_q[14];
            if (dev_wr && (mar_q == ADDR_MCR))  mcr_q    <= mdr_q;

            if (ddr_take)        dsr_rdy_q <= 1'b0;
            else if (disp_ready) dsr_rdy_q <= 1'b1;

            disp_valid_q <= ddr_take;
            if (ddr_take) disp_data_q <= mdr_q[7:0];
        end
    end

`ifdef LC3_MEM_INT_EN
    logic kb_irq_q;

    // Keyboard interrupt request, one cycle behind KBSR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) kb_irq_q <= 1'b0;
        else        kb_irq_q <= kb_rdy_q & kb_ie_q;
    end

    assign kb_irq = kb_irq_q;
`else
    assign kb_irq = 1'b0;
`endif

    assign mar_out    = mar_q;
    assign mdr_out    = mdr_q;
    assign r          = r_q;
    assign mem_addr   = mar_q;
    assign mem_wdata  = mdr_q;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
    assign run        = mcr_q[15];
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: directed accesses, an architectural
// register model, and a per-cycle compare process.
module tb_lc3_mem_ctrl;
    localparam int unsigned MEM_LAT = 2;
`ifdef LC3_MEM_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    logic        clk, rst_n;
    logic [15:0] bus_in;
    logic        ld_mar, ld_mdr, mio_en, r_w;
    logic [15:0] mar_out, mdr_out;
    logic        r;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_re, mem_we;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready, run, kb_irq;

    lc3_mem_ctrl #(.MEM_LATENCY(MEM_LAT), .DEV_BASE(16'hFE00)) dut (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
        .mio_en(mio_en), .r_w(r_w), .mar_out(mar_out), .mdr_out(mdr_out), .r(r),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .kb_valid(kb_valid), .kb_data(kb_data),
        .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready),
        .run(run), .kb_irq(kb_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // External memory: 16 words selected by address[15:12].
    logic [15:0] mem_img [0:15] = '{3: 16'h1234, 5: 16'h5555, default: 16'h0000};
    always @(posedge clk) begin
        if (mem_we) mem_img[mem_addr[15:12]] <= mem_wdata;
        mem_rdata <= mem_img[mem_addr[15:12]];
    end

    // Architectural model state and expected strobes.
    logic [15:0] m_mem [0:15] = '{3: 16'h1234, 5: 16'h5555, default: 16'h0000};
    logic [15:0] m_mar, m_mdr, m_mcr;
    logic        m_kb_rdy, m_kb_ie, m_dsr_rdy, m_dsr_ie;
    logic [7:0]  m_kbdr, m_disp;
    logic        exp_r, exp_re, exp_we, exp_dv;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mar = 16'h0; m_mdr = 16'h0; m_mcr = 16'h8000;
        m_kb_rdy = 1'b0; m_kb_ie = 1'b0; m_kbdr = 8'h0;
        m_dsr_rdy = 1'b1; m_dsr_ie = 1'b0; m_disp = 8'h0;
        exp_r = 1'b0; exp_re = 1'b0; exp_we = 1'b0; exp_dv = 1'b0;
    endtask

    function automatic logic [15:0] dev_read(input logic [15:0] a);
        case (a)
            16'hFE00: return {m_kb_rdy, m_kb_ie, 14'h0};
            16'hFE02: return {8'h00, m_kbdr};
            16'hFE04: return {m_dsr_rdy, m_dsr_ie, 14'h0};
            16'hFFFE: return m_mcr;
            default:  return 16'h0000;
        endcase
    endfunction

    // Every-cycle comparison of all outputs against the model.
    logic irq_prev = 1'b0;
    always @(negedge clk) begin
        if (chk_on) begin
            chk("mar_out", mar_out, m_mar);
            chk("mdr_out", mdr_out, m_mdr);
            chk("mem_addr", mem_addr, m_mar);
            chk("mem_wdata", mem_wdata, m_mdr);
            chk("r", 16'(r), 16'(exp_r));
            chk("mem_re", 16'(mem_re), 16'(exp_re));
            chk("mem_we", 16'(mem_we), 16'(exp_we));
            chk("disp_valid", 16'(disp_valid), 16'(exp_dv));
            chk("disp_data", 16'(disp_data), 16'(m_disp));
            chk("run", 16'(run), 16'(m_mcr[15]));
            chk("kb_irq", 16'(kb_irq), 16'(irq_prev & INT_EN));
            irq_prev <= m_kb_rdy & m_kb_ie;
        end else begin
            irq_prev <= 1'b0;
        end
    end

    task automatic load_mar(input logic [15:0] v);
        @(posedge clk); #1; ld_mar = 1'b1; bus_in = v;
        @(posedge clk); #1; ld_mar = 1'b0; m_mar = v;
    endtask

    task automatic load_mdr(input logic [15:0] v);
        @(posedge clk); #1; ld_mdr = 1'b1; mio_en = 1'b0; bus_in = v;
        @(posedge clk); #1; ld_mdr = 1'b0; m_mdr = v;
    endtask

    task automatic kb_char(input logic [7:0] c);
        @(posedge clk); #1; kb_valid = 1'b1; kb_data = c;
        @(posedge clk); #1; kb_valid = 1'b0; m_kb_rdy = 1'b1; m_kbdr = c;
    endtask

    task automatic disp_pulse();
        @(posedge clk); #1; disp_ready = 1'b1;
        @(posedge clk); #1; disp_ready = 1'b0; m_dsr_rdy = 1'b1;
    endtask

    // One access at the current MAR; mio_en held `hold` cycles past ready.
    task automatic access(input logic wr, input logic ld, input int hold,
                          input logic kb_same, input logic [7:0] kb_c);
        logic is_dev;
        int   lat;
        logic [15:0] rd;
        is_dev = (m_mar >= 16'hFE00);
        lat    = is_dev ? 1 : int'(MEM_LAT) + 1;
        @(posedge clk); #1;
        mio_en = 1'b1; r_w = wr; ld_mdr = ld;
        if (kb_same) begin kb_valid = 1'b1; kb_data = kb_c; end
        for (int k = 1; k <= lat + hold; k++) begin
            @(posedge clk); #1;
            kb_valid = 1'b0;
            exp_re = !is_dev && !wr && (k == 1);
            exp_we = !is_dev && wr && (k == 1);
            exp_r  = (k >= lat);
            exp_dv = 1'b0;
            if (k == lat) begin
                if (!is_dev) begin
                    if (wr) m_mem[m_mar[15:12]] = m_mdr;
                    else if (ld) m_mdr = m_mem[m_mar[15:12]];
                end else if (!wr) begin
                    rd = dev_read(m_mar);
                    if (ld) m_mdr = rd;
                    if (m_mar == 16'hFE02) m_kb_rdy = 1'b0;
                end else begin
                    case (m_mar)
                        16'hFE00: m_kb_ie  = m_mdr[14];
                        16'hFE04: m_dsr_ie = m_mdr[14];
                        16'hFFFE: m_mcr    = m_mdr;
                        16'hFE06: if (m_dsr_rdy) begin
                            m_disp = m_mdr[7:0]; exp_dv = 1'b1; m_dsr_rdy = 1'b0;
                        end
                        default: ;
                    endcase
                end
                if (kb_same) begin m_kb_rdy = 1'b1; m_kbdr = kb_c; end
            end
        end
        mio_en = 1'b0; r_w = 1'b0; ld_mdr = 1'b0;
        @(posedge clk); #1;
        exp_r = 1'b0; exp_re = 1'b0; exp_we = 1'b0; exp_dv = 1'b0;
    endtask

    task automatic dev_rd_chk(input logic [15:0] a, input string name, input logic [15:0] exp);
        load_mar(a);
        access(1'b0, 1'b1, 0, 1'b0, 8'h00);
        chk(name, mdr_out, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; bus_in = 16'h0; ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0;
        r_w = 1'b0; kb_valid = 1'b0; kb_data = 8'h0; disp_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mar", mar_out, 16'h0000);
        chk("rst_mdr", mdr_out, 16'h0000);
        chk("rst_r", 16'(r), 16'h0);
        chk("rst_mem_re", 16'(mem_re), 16'h0);
        chk("rst_mem_we", 16'(mem_we), 16'h0);
        chk("rst_disp_valid", 16'(disp_valid), 16'h0);
        chk("rst_disp_data", 16'(disp_data), 16'h0);
        chk("rst_run", 16'(run), 16'h1);
        chk("rst_kb_irq", 16'(kb_irq), 16'h0);
        rst_n = 1'b1;
        chk_on = 1'b1;

        dev_rd_chk(16'hFE04, "dsr_reset", 16'h8000);
        dev_rd_chk(16'hFFFE, "mcr_reset", 16'h8000);

        // Memory read and write; write holds mio_en to keep r asserted.
        dev_rd_chk(16'h3000, "mem_rd_x3000", 16'h1234);
        load_mdr(16'hBEEF);
        load_mar(16'h4000);
        access(1'b1, 1'b0, 3, 1'b0, 8'h00);
        load_mdr(16'h0000);
        access(1'b0, 1'b1, 0, 1'b0, 8'h00);
        chk("mem_rd_x4000", mdr_out, 16'hBEEF);

        // Keyboard.
        kb_char(8'h41);
        dev_rd_chk(16'hFE00, "kbsr_ready", 16'h8000);
        dev_rd_chk(16'hFE02, "kbdr_A", 16'h0041);
        dev_rd_chk(16'hFE00, "kbsr_clear", 16'h0000);
        kb_char(8'h42);
        load_mar(16'hFE02);
        access(1'b0, 1'b1, 0, 1'b1, 8'h43);
        chk("kbdr_old_char", mdr_out, 16'h0042);
        dev_rd_chk(16'hFE00, "kbsr_set_wins", 16'h8000);
        dev_rd_chk(16'hFE02, "kbdr_new_char", 16'h0043);

        // Display: accepted write, dropped write, ready, IE bit.
        load_mdr(16'h0042);
        load_mar(16'hFE06);
        access(1'b1, 1'b0, 0, 1'b0, 8'h00);
        chk("disp_data_42", 16'(disp_data), 16'h0042);
        dev_rd_chk(16'hFE04, "dsr_busy", 16'h0000);
        load_mdr(16'h0043);
        load_mar(16'hFE06);
        access(1'b1, 1'b0, 0, 1'b0, 8'h00);
        chk("ddr_dropped", 16'(disp_data), 16'h0042);
        disp_pulse();
        dev_rd_chk(16'hFE04, "dsr_ready", 16'h8000);
        load_mdr(16'h4000);
        access(1'b1, 1'b0, 0, 1'b0, 8'h00);
        dev_rd_chk(16'hFE04, "dsr_ie", 16'hC000);

        // Unmapped device address.
        load_mdr(16'hFFFF);
        load_mar(16'hFE08);
        access(1'b1, 1'b0, 0, 1'b0, 8'h00);
        dev_rd_chk(16'hFE08, "unmapped", 16'h0000);

        // Keyboard interrupt enable.
        load_mdr(16'h4000);
        load_mar(16'hFE00);
        access(1'b1, 1'b0, 0, 1'b0, 8'h00);
        kb_char(8'h55);
        @(posedge clk); #1;
        chk("kb_irq_lit", 16'(kb_irq), 16'(INT_EN));
        dev_rd_chk(16'hFE00, "kbsr_ie_ready", 16'hC000);

        // MCR clears run; memory still completes.
        load_mdr(16'h0000);
        load_mar(16'hFFFE);
        access(1'b1, 1'b0, 0, 1'b0, 8'h00);
        chk("run_off", 16'(run), 16'h0);
        dev_rd_chk(16'h3000, "mem_rd_run0", 16'h1234);

        // Make DSR busy, then reset in the middle of a memory read.
        load_mdr(16'h0044);
        load_mar(16'hFE06);
        access(1'b1, 1'b0, 0, 1'b0, 8'h00);
        load_mar(16'h5000);
        @(posedge clk); #1;
        chk_on = 1'b0;
        mio_en = 1'b1; r_w = 1'b0; ld_mdr = 1'b1;
        @(posedge clk); #1;
        chk("re_before_rst", 16'(mem_re), 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_r", 16'(r), 16'h0);
        chk("rst_mid_mem_re", 16'(mem_re), 16'h0);
        mio_en = 1'b0; ld_mdr = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        chk_on = 1'b1;
        chk("run_after_rst", 16'(run), 16'h1);
        dev_rd_chk(16'hFE04, "dsr_after_rst", 16'h8000);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
